// File: rtl/imem_loader.sv
// imem_loader: write-side companion of the byte-addressable instruction memory.
// Accepts a byte stream over a valid/ready handshake. Each byte is written into
// consecutive instruction-memory locations starting at BASE_ADDR, one byte per cycle.
// The core is held in reset (cpu_hold) until the first good image load completes.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a checksum[7:0] output.
// This output is the mod-256 sum of every byte accepted since the last accepted start.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, length     load request (one cycle) and image length in bytes
//   s_valid, s_data   byte stream in
//   s_ready           loader accepts a byte this cycle
//   wr_en/addr/data   instruction-memory byte write port
//   busy, done        loading / one-cycle completion pulse
//   error             sticky bad-request flag, cleared by the next accepted start
//   cpu_hold          core reset hold; drops after the first completed image
//   checksum          (IMEM_LOADER_CHECKSUM_EN only) running byte sum
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | accepting bytes, one write issued per accepted byte
// S_FLUSH | last byte accepted; its write strobe is on the bus
// S_DONE  | done pulse cycle; returns to idle unless restarted
// S_ERROR | rejected request; waits for a new start
module imem_loader #(
  parameter int unsigned ARRAY_SIZE = 2048,
  parameter logic [31:0] BASE_ADDR  = 32'd0   // must be word-aligned
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] length,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic        cpu_hold
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERROR} state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic        s_ready_q, s_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        start_ok;
  logic        bad_req;
  logic        hs;
  logic [32:0] end_addr;

  // 33-bit sum so a huge length cannot wrap past the bound check.
  assign end_addr = {1'b0, BASE_ADDR} + {1'b0, length};
  assign bad_req  = (length[1:0] != 2'b00) || (end_addr > 33'(ARRAY_SIZE));
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                              (state_q == S_ERROR));
  assign hs       = (state_q == S_LOAD) && s_valid && s_ready_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    s_ready_d  = s_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    error_d    = error_q;
    cpu_hold_d = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (start_ok) csum_d = 8'd0;
    else if (hs)  csum_d = csum_q + s_data;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start_ok) begin
          if (bad_req) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (length == 32'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            error_d = 1'b0;
          end else begin
            state_d   = S_LOAD;
            len_d     = length;
            cnt_d     = 32'd0;
            error_d   = 1'b0;
            s_ready_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + cnt_q;
          wr_data_d = s_data;
          cnt_d     = cnt_q + 32'd1;
          // Drop ready together with the last write so no extra byte is taken.
          if (cnt_q == len_q - 32'd1) begin
            s_ready_d = 1'b0;
            state_d   = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d    = S_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        s_ready_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= 32'd0;
      cnt_q      <= 32'd0;
      s_ready_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule
